serial_paralelo_rx: RTL and testbench

- Receive-side deserializer for the PHY lane: takes the 1-bit MSB-first stream produced by the transmit serializer and rebuilds 8-bit symbols.
- The transmitter sends the COMMA symbol 8'hBC whenever it has no valid data. The receiver uses that symbol to find the byte boundary.
- After COMMA_CNT consecutive aligned commas, the receiver declares the link active. From then on it presents non-comma bytes as valid data, one byte every 8 clocks.

---
 rtl/serial_paralelo_rx.sv | 126 ++++++++++++
 tb/tb_serial_paralelo_rx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_rx.sv
// Deserializer for the PHY receive lane. It finds the byte boundary from the comma symbol and rebuilds MSB-first bytes.
// States: SEARCH = hunting for a comma in every window | ALIGN = confirming commas on boundaries | ACTIVE = locked, delivering bytes
module serial_paralelo_rx #(
    parameter logic [7:0]  COMMA     = 8'hBC,
    parameter int unsigned COMMA_CNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_TGT = 4'(COMMA_CNT);

    state_t     r_state, w_state_nxt;
    // The oldest bit of the shift register never reaches the window, so only seven bits are kept.
    logic [6:0] r_sr;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [3:0] r_comma_seen, w_comma_seen_nxt;
    logic [7:0] r_data_out, w_data_out_nxt;
    logic       r_valid_out, w_valid_nxt;
    logic       r_byte_strobe, w_strobe_nxt;
    logic       r_active, w_active_nxt;

    logic [7:0] w_win;
    logic       w_is_comma;
    logic       w_boundary;
    logic [3:0] w_seen_inc;

    assign w_win      = {r_sr, data_in};
    assign w_is_comma = (w_win == COMMA);
    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_seen_inc = (r_comma_seen >= CNT_TGT) ? CNT_TGT : (r_comma_seen + 4'd1);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state      <= SEARCH;
            r_sr         <= '0;
            r_bit_cnt    <= '0;
            r_comma_seen <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sr         <= w_win[6:0];
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_comma_seen <= w_comma_seen_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_comma_seen_nxt = r_comma_seen;
        case (r_state)
            SEARCH: begin
                if (w_is_comma) begin
                    w_bit_cnt_nxt    = 3'd0;
                    w_comma_seen_nxt = 4'd1;
                    w_state_nxt      = (CNT_TGT == 4'd1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_comma_seen_nxt = w_seen_inc;
                        if (w_seen_inc == CNT_TGT) begin
                            w_state_nxt = ACTIVE;
                        end
                    end else begin
                        w_comma_seen_nxt = 4'd0;
                        w_state_nxt      = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
            default: begin
                w_state_nxt = SEARCH;
            end
        endcase
    end

    always_comb begin
        w_data_out_nxt = r_data_out;
        w_valid_nxt    = r_valid_out;
        w_strobe_nxt   = 1'b0;
        w_active_nxt   = (w_state_nxt == ACTIVE);
        if ((r_state == ACTIVE) && w_boundary) begin
            w_strobe_nxt = 1'b1;
            if (w_is_comma) begin
                w_valid_nxt = 1'b0;
            end else begin
                w_valid_nxt    = 1'b1;
                w_data_out_nxt = w_win;
            end
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_data_out    <= '0;
            r_valid_out   <= 1'b0;
            r_byte_strobe <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            r_data_out    <= w_data_out_nxt;
            r_valid_out   <= w_valid_nxt;
            r_byte_strobe <= w_strobe_nxt;
            r_active      <= w_active_nxt;
        end
    end

    assign data_out    = r_data_out;
    assign valid_out   = r_valid_out;
    assign byte_strobe = r_byte_strobe;
    assign active      = r_active;
endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: bit streams are built per scenario and compared cycle by cycle with a position-based model.
module tb_serial_paralelo_rx;
    localparam logic [7:0] COMMA = 8'hBC;
    localparam int MAXB = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic d0 = 1'b0;
    logic d1 = 1'b0;
    logic [7:0] o0_d, o1_d;
    logic o0_v, o0_s, o0_a, o1_v, o1_s, o1_a;

    int checks = 0;
    int errors = 0;

    logic        bits  [MAXB];
    int          nb;
    logic [10:0] obs   [MAXB];
    logic [10:0] ref_v [MAXB];

    always #5 clk = ~clk;

    serial_paralelo_rx dut0 (
        .clk_32f(clk), .reset(rst), .data_in(d0),
        .data_out(o0_d), .valid_out(o0_v), .byte_strobe(o0_s), .active(o0_a)
    );

    serial_paralelo_rx #(.COMMA(8'hBC), .COMMA_CNT(1)) dut1 (
        .clk_32f(clk), .reset(rst), .data_in(d1),
        .data_out(o1_d), .valid_out(o1_v), .byte_strobe(o1_s), .active(o1_a)
    );

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) begin
            bits[nb] = b[k];
            nb++;
        end
    endtask

    task automatic push_commas(input int n);
        for (int i = 0; i < n; i++) push_byte(COMMA);
    endtask

    task automatic push_rand_bits(input int n);
        for (int i = 0; i < n; i++) begin
            bits[nb] = 1'($urandom_range(0, 1));
            nb++;
        end
    endtask

    // Model: lock position is the edge of the first full comma window; later symbols sit at multiples of 8 from it.
    task automatic run_model(input int cnt);
        logic [7:0] w;
        int mode, anchor, seen;
        logic s, v;
        logic [7:0] d;
        mode = 0; anchor = 0; seen = 0; v = 1'b0; d = 8'h00;
        for (int t = 0; t < nb; t++) begin
            w = 8'h00;
            for (int k = 7; k >= 0; k--) w = {w[6:0], (t - k >= 0) ? bits[t - k] : 1'b0};
            s = 1'b0;
            if (mode == 2) begin
                if ((t - anchor) % 8 == 0) begin
                    s = 1'b1;
                    if (w != COMMA) begin v = 1'b1; d = w; end
                    else v = 1'b0;
                end
            end else if (mode == 1) begin
                if ((t - anchor) % 8 == 0) begin
                    if (w == COMMA) begin
                        seen = seen + 1;
                        if (seen == cnt) mode = 2;
                    end else begin
                        seen = 0;
                        mode = 0;
                    end
                end
            end else if (w == COMMA) begin
                anchor = t;
                seen = 1;
                mode = (cnt == 1) ? 2 : 1;
            end
            ref_v[t] = {(mode == 2), s, v, d};
        end
    endtask

    task automatic drive(input int which);
        for (int t = 0; t < nb; t++) begin
            if (which == 0) d0 = bits[t]; else d1 = bits[t];
            @(posedge clk);
            #1;
            obs[t] = (which == 0) ? {o0_a, o0_s, o0_v, o0_d} : {o1_a, o1_s, o1_v, o1_d};
        end
        d0 = 1'b0;
        d1 = 1'b0;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #2 rst = 1'b0;
        d0 = 1'b0;
        d1 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d0 = ~d0;
            d1 = ~d1;
            @(posedge clk);
            #1;
            checks++;
            if ({o0_a, o0_s, o0_v, o0_d, o1_a, o1_s, o1_v, o1_d} !== 22'd0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got %h/%h required 0/0 {active,strobe,valid,data}", i,
                         {o0_a, o0_s, o0_v, o0_d}, {o1_a, o1_s, o1_v, o1_d});
            end
        end
        #1 rst = 1'b1;
        nb = 0;
        for (int i = 0; i < 40; i++) begin bits[nb] = 1'b0; nb++; end
        run_model(4);
        drive(0);
        for (int t = 0; t < nb; t++) begin
            checks++;
            if (obs[t] !== ref_v[t] || obs[t] !== 11'd0) begin
                errors++;
                $display("FAIL zeros t=%0d got %h required %h", t, obs[t], ref_v[t]);
            end
        end
    endtask

    task automatic test_lock;
        do_reset;
        nb = 0;
        push_rand_bits(3);
        push_commas(4);
        push_byte(8'h5A);
        push_byte(8'h3C);
        run_model(4);
        drive(0);
        for (int t = 0; t < nb; t++) begin
            checks++;
            if (obs[t] !== ref_v[t]) begin
                errors++;
                $display("FAIL lock t=%0d got %h required %h", t, obs[t], ref_v[t]);
            end
        end
        checks++;
        if (obs[nb - 1] !== {3'b111, 8'h3C}) begin
            errors++;
            $display("FAIL lock_last got %h required %h", obs[nb - 1], {3'b111, 8'h3C});
        end
    endtask

    task automatic test_comma_hold;
        do_reset;
        nb = 0;
        push_commas(4);
        push_byte(8'hA1);
        push_byte(8'hBC);
        push_byte(8'h7E);
        run_model(4);
        drive(0);
        for (int t = 0; t < nb; t++) begin
            checks++;
            if (obs[t] !== ref_v[t]) begin
                errors++;
                $display("FAIL comma_hold t=%0d got %h required %h", t, obs[t], ref_v[t]);
            end
        end
    endtask

    task automatic test_false_lock;
        do_reset;
        nb = 0;
        push_commas(2);
        push_byte(8'h00);
        push_commas(4);
        push_byte(8'hFF);
        run_model(4);
        drive(0);
        for (int t = 0; t < nb; t++) begin
            checks++;
            if (obs[t] !== ref_v[t]) begin
                errors++;
                $display("FAIL false_lock t=%0d got %h required %h", t, obs[t], ref_v[t]);
            end
        end
        checks++;
        if (obs[31] !== 11'd0) begin
            errors++;
            $display("FAIL false_lock_reject got %h required 0", obs[31]);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        nb = 0;
        push_commas(4);
        push_byte(8'h5A);
        bits[nb] = 1'b1; bits[nb + 1] = 1'b0; bits[nb + 2] = 1'b1;
        nb += 3;
        run_model(4);
        drive(0);
        for (int t = 0; t < nb; t++) begin
            checks++;
            if (obs[t] !== ref_v[t]) begin
                errors++;
                $display("FAIL pre_reset t=%0d got %h required %h", t, obs[t], ref_v[t]);
            end
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({o0_a, o0_s, o0_v, o0_d} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset got %h required 0", {o0_a, o0_s, o0_v, o0_d});
        end
        @(posedge clk);
        #2 rst = 1'b1;
        nb = 0;
        push_commas(3);
        push_byte(8'h5A);
        push_commas(4);
        push_byte(8'h5A);
        run_model(4);
        drive(0);
        for (int t = 0; t < nb; t++) begin
            checks++;
            if (obs[t] !== ref_v[t]) begin
                errors++;
                $display("FAIL post_reset t=%0d got %h required %h", t, obs[t], ref_v[t]);
            end
        end
    endtask

    task automatic test_single_comma;
        do_reset;
        nb = 0;
        push_byte(8'hBC);
        push_byte(8'h12);
        run_model(1);
        drive(1);
        for (int t = 0; t < nb; t++) begin
            checks++;
            if (obs[t] !== ref_v[t]) begin
                errors++;
                $display("FAIL cnt1 t=%0d got %h required %h", t, obs[t], ref_v[t]);
            end
        end
        checks++;
        if (obs[nb - 1] !== {3'b111, 8'h12}) begin
            errors++;
            $display("FAIL cnt1_last got %h required %h", obs[nb - 1], {3'b111, 8'h12});
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 8; it++) begin
            int which;
            which = (it < 6) ? 0 : 1;
            do_reset;
            nb = 0;
            push_rand_bits($urandom_range(0, 12));
            push_commas((which == 0) ? 4 : 1);
            for (int i = 0; i < 10; i++) begin
                if ($urandom_range(0, 3) == 0) push_byte(COMMA);
                else push_byte(8'($urandom_range(0, 255)));
            end
            run_model((which == 0) ? 4 : 1);
            drive(which);
            for (int t = 0; t < nb; t++) begin
                checks++;
                if (obs[t] !== ref_v[t]) begin
                    errors++;
                    $display("FAIL random it=%0d t=%0d got %h required %h", it, t, obs[t], ref_v[t]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_lock;
        test_comma_hold;
        test_false_lock;
        test_reset_mid;
        test_single_comma;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
